// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : FSM encoding (IDLE, GRANT)
//   REQ_N       : number of requesters
//   SEL_W       : width of the grant index
//   rr_pick     : round-robin winner from pointer + request vector
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  // Scan last+1, last+2, ... modulo REQ_N and return the first set bit.
  // The loop runs from the farthest candidate (last itself) toward the
  // nearest, so the nearest set bit overwrites earlier hits.
  // If no bit is set the result is 'last'; callers only use it when |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] last,
                                               input logic [REQ_N-1:0] req);
    logic [SEL_W-1:0] idx;
    rr_pick = last;
    for (int i = REQ_N; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4_w.sv
// WIDTH-parameterized combinational 4:1 multiplexer.
//   in1..in4 : data inputs (WIDTH)
//   s        : select, 0 picks in1 ... 3 picks in4
//   y        : selected data (WIDTH)
module mux4_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = in1;
    case (s)
      2'd0: y = in1;
      2'd1: y = in2;
      2'd2: y = in3;
      2'd3: y = in4;
      default: y = in1;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select line of a shared 4:1 data mux.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no grant; arbitrates among req, loads sel on any request
// GRANT  | requester sel owns y; beats move on y_valid && y_ready
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req[3:0]      : requests, bit i belongs to in(i+1)
//   in1..in4      : requester data, stable while requested
//   y             : in(sel+1), combinational
//   y_valid       : y carries a beat (req[sel] while granted)
//   y_ready       : downstream accepts the beat
//   sel[1:0]      : registered grant index
//   ack[3:0]      : one-hot, bit sel pulses on each transfer
//   busy          : FSM is in GRANT
//
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN -- caps a grant at
// HOLD_MAX transfers, then releases it even if the request stays high.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic             busy
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("mux4_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] last, last_nxt;
  logic             hold_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      last  <= '1;   // pointer at 3 so requester 0 wins first
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  logic       xfer;

  assign xfer = y_valid & y_ready;

  // Held at zero through IDLE, so every grant starts from a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (xfer) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign hold_done = xfer && (hold_cnt == HOLD_LAST);
`else
  assign hold_done = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    y_valid   = 1'b0;
    busy      = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = rr_pick(last, req);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        busy    = 1'b1;
        y_valid = req[sel];
        if (y_valid && y_ready) ack[sel] = 1'b1;
        // Released index becomes the lowest priority for the next pick.
        if (!req[sel] || hold_done) begin
          state_nxt = IDLE;
          last_nxt  = sel;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .s   (sel),
    .y   (y)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] in1, in2, in3, in4;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] sel;
  logic [3:0] ack;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel),
    .ack     (ack),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = 4'b0000;
    y_ready = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] s, input logic rdy);
    logic [7:0] d;
    d = (s == 2'd0) ? in1 : (s == 2'd1) ? in2 : (s == 2'd2) ? in3 : in4;
    chk({tag, "_sel"},   sel, s);
    chk({tag, "_busy"},  busy, 1'b1);
    chk({tag, "_valid"}, y_valid, 1'b1);
    chk({tag, "_y"},     y, d);
    chk({tag, "_ack"},   ack, rdy ? (4'b0001 << s) : 4'b0000);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    in1 = 8'hA5; in2 = 8'h22; in3 = 8'h33; in4 = 8'h44;

    // Reset values.
    do_reset();
    chk("rst_sel",   sel, 2'd0);
    chk("rst_valid", y_valid, 1'b0);
    chk("rst_ack",   ack, 4'b0000);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_y",     y, 8'hA5);

    // Single requester, continuous beats.
    req = 4'b0001; y_ready = 1'b1; #1;
    chk("t1_idle_valid", y_valid, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) chk_grant("t1", 2'd0, 1'b1);
    req = 4'b0000; #1;
    chk("t1_rel_valid", y_valid, 1'b0);
    chk("t1_rel_ack",   ack, 4'b0000);
    tick();
    chk("t1_idle_busy", busy, 1'b0);

    // Round robin: all requesting, each drops after one beat.
    do_reset();
    req = 4'b1111; y_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_grant("rr", 2'(order[k]), 1'b1);
      req[order[k]] = 1'b0; #1;
      chk("rr_drop_valid", y_valid, 1'b0);
      tick();
      chk("rr_gap_busy", busy, 1'b0);
      chk("rr_gap_valid", y_valid, 1'b0);
      req = 4'b1111;
      tick();
    end

    // Backpressure on requester 2.
    do_reset();
    req = 4'b0100; y_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_grant("bp", 2'd2, 1'b0);
      tick();
    end
    y_ready = 1'b1; #1;
    chk_grant("bp_go", 2'd2, 1'b1);
    req = 4'b0000;
    tick();

    // Two requesters held, ready high.
    do_reset();
    req = 4'b0011; y_ready = 1'b1;
    tick();
`ifdef MUX_ARB_HOLD_LIMIT_EN
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        chk_grant("hold", 2'(g), 1'b1);
        tick();
      end
      chk("hold_gap_busy", busy, 1'b0);
      tick();
    end
    chk_grant("hold_wrap", 2'd0, 1'b1);
`else
    for (int i = 0; i < 12; i++) begin
      chk_grant("nohold", 2'd0, 1'b1);
      tick();
    end
`endif

    // Reset mid-burst on requester 3.
    do_reset();
    req = 4'b1000; y_ready = 1'b1;
    tick();
    chk_grant("mr_pre", 2'd3, 1'b1);
    tick();
    chk_grant("mr_pre2", 2'd3, 1'b1);
    #2 rst_n = 1'b0; #1;
    chk("mr_valid", y_valid, 1'b0);
    chk("mr_busy",  busy, 1'b0);
    chk("mr_ack",   ack, 4'b0000);
    chk("mr_sel",   sel, 2'd0);
    chk("mr_y",     y, 8'hA5);
    tick();
    rst_n = 1'b1; #1;
    chk("mr_rel_busy", busy, 1'b0);
    tick();
    chk_grant("mr_post", 2'd3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer among four requesters and drives its select line. Each requester raises a request and holds its data stable. The arbiter grants one requester at a time and steers that requester's data to a single output with a valid/ready handshake. It sits directly in front of the shared 4:1 mux path and is the only block allowed to drive `sel`.

## Interface
Parameters:
- `WIDTH`, default 8: data width of each input and of `y`.
- `HOLD_MAX`, default 4: maximum transfers per grant. Used only when `MUX_ARB_HOLD_LIMIT_EN` is defined. Legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: per-requester request; bit i belongs to `in(i+1)`.
- `in1`..`in4` input WIDTH each: requester data; each must hold stable while its request is high.
- `y` output WIDTH: muxed data, equal to `in(sel+1)`.
- `y_valid` output 1: `y` carries a valid beat.
- `y_ready` input 1: downstream accepts a beat.
- `sel` output 2: registered current grant index.
- `ack` output 4: one-hot; bit `sel` pulses in any cycle where `y_valid && y_ready`.
- `busy` output 1: high while the FSM is in GRANT.

## Operation
- FSM states are IDLE and GRANT.
- Reset values:
  - state = IDLE
  - `sel` = 2'b00
  - priority pointer `last` = 2'b11, so requester 0 wins first
  - `y_valid` = 0, `ack` = 0, `busy` = 0
  - hold counter = 0
  - `y` = `in1`, since it is combinational from `sel` = 0
- IDLE, no request: no `req` bit set; stay in IDLE.
- IDLE, arbitration: if any `req` bit is set, the winner is the first set bit scanning `last+1, last+2, …` modulo 4. Load `sel` = winner, go to GRANT.
- GRANT, outputs: `y_valid` = `req[sel]`. `busy` = 1.
- GRANT, transfer: a transfer occurs when `y_valid && y_ready`. `ack[sel]` = 1 in that same cycle (combinational).
- GRANT, release: if `req[sel]` is 0, go to IDLE and set `last` = `sel`.
- GRANT, hold: while `req[sel]` is 1, stay in GRANT. The grant is never revoked while the requester is waiting on `y_ready`.
- `y` is a pure combinational mux of `in1..in4` by `sel`, valid or not.
- Requests on other lines do not pre-empt a granted requester.

## Timing
- Grant latency: `req` rises in cycle N with the FSM in IDLE → `sel` and `busy` are updated at the edge ending cycle N → `y_valid` is high in cycle N+1.
- Release bubble: the granted `req` drops in cycle M → state is IDLE in M+1 → next grant is visible in M+2. There is exactly one idle cycle between grants.
- Back-to-back beats: one transfer per cycle while `req[sel]` and `y_ready` are both high.
- Backpressure: with `y_ready` = 0, `y_valid`, `sel` and `y` stay constant. `ack` = 0.
- Simultaneous request and grant-holder release: arbitration happens in the IDLE cycle. The released index has the lowest priority.
- Reset mid-transfer: `rst_n` low forces all outputs to their reset values immediately. No `ack` is produced. The beat in flight is lost.

## Configuration
`MUX_ARB_HOLD_LIMIT_EN`:
- Defined:
  - An 8-bit hold counter counts transfers in GRANT and is cleared on entry to GRANT.
  - A transfer with counter == `HOLD_MAX`-1 forces GRANT → IDLE and sets `last` = `sel`, even if `req[sel]` is still high. This guarantees fairness.
- Undefined:
  - No counter is built.
  - A requester keeps the grant until it drops `req`.

## Structure
- Shared package `mux_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, GRANT}
  - `REQ_N` = 4
  - `SEL_W` = 2
  - the round-robin pick function (pointer + request vector → index)
- One sub-module, `mux4_w`: WIDTH-parameterized combinational 4:1 mux (`in1..in4`, `s`, `y`), instantiated once for the data path.

## Test plan
- Reset then `req`=4'b0001, `in1`=8'hA5, `y_ready`=1 → `sel`=0 one cycle later, `y`=8'hA5, `y_valid`=1, `ack`=4'b0001 each cycle.
- `req`=4'b1111 held, each requester drops `req` after 1 beat → grant order 0,1,2,3,0 with one idle cycle between grants.
- Grant on requester 2, `y_ready`=0 for 5 cycles → `sel`=2, `y_valid`=1 and `ack`=0 throughout. `y_ready`=1 → `ack`=4'b0100.
- `MUX_ARB_HOLD_LIMIT_EN`, `HOLD_MAX`=4, `req`=4'b0011 held, `y_ready`=1 → 4 beats on `sel`=0, idle cycle, then 4 beats on `sel`=1.
- Same stimulus without the macro → `sel` stays 0 indefinitely.
- `rst_n` pulsed low mid-burst on `sel`=3 → `y_valid`, `busy`, `ack` go 0 immediately and `sel`=0. After release with `req`=4'b1000, `sel`=3 next cycle.
